// File: rtl/dptr_pkg.sv
// Shared constants, enums and instruction classification for the multi-cycle
// MIPS-subset datapath.
package dptr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [1:0] {
    K_RTYPE,
    K_LW,
    K_SW
  } kind_t;

  typedef struct packed {
    kind_t   kind;
    alu_op_t alu_op;
    logic    illegal;
  } dec_t;

  // Opcode/funct classification only; register-index range checks depend on
  // the bank size and live in the datapath.
  function automatic dec_t decode_op(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.kind    = K_RTYPE;
    d.alu_op  = ALU_ADD;
    d.illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_NOR:  d.alu_op = ALU_NOR;
          FN_SLT:  d.alu_op = ALU_SLT;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_LW:   d.kind = K_LW;
      OP_SW:   d.kind = K_SW;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dptr_alu.sv
// Combinational ALU for the multi-cycle datapath: add/sub/and/or/nor/signed
// set-less-than, with a zero flag on the result.
module dptr_alu
  import dptr_pkg::*;
#(
  parameter int DW = 32
) (
  input  alu_op_t        op,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic [DW-1:0]  y,
  output logic           zf
);

  logic lt;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    y  = '0;
    lt = $signed(a) < $signed(b);
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = DW'(lt);
      default: y = '0;
    endcase
  end

  assign zf = (y == '0);

endmodule

// File: rtl/dptr_multiciclo.sv
// Multi-cycle MIPS-subset datapath: R-type, LW and SW with an internal register
// bank and a req/ack data-memory port guarded by a timeout.
module dptr_multiciclo
  import dptr_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int NREG    = 32,
  parameter int MEM_TMO = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  output logic          instr_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zf,
  output logic [1:0]    err
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CW = $clog2(MEM_TMO + 1);

  state_t        state, state_nx;
  logic [31:0]   instr_q;
  logic [DW-1:0] rf [NREG];

  logic [DW-1:0] a_q, b_q, rt_q, alu_q, ld_q;
  logic          alu_zf_q;
  kind_t         kind_q;
  alu_op_t       alu_op_q;
  logic [1:0]    err_pend;
  logic [CW-1:0] tmo_cnt;

  logic [4:0]    rs, rt, rd, dest;
  dec_t          dec;
  logic          illegal, tmo_hit;
  logic [DW-1:0] rs_val, rt_val, sext_imm, alu_y;
  logic          alu_zf;

  function automatic logic idx_ok(input logic [4:0] idx);
    return int'(idx) < NREG;
  endfunction

  assign rs   = instr_q[25:21];
  assign rt   = instr_q[20:16];
  assign rd   = instr_q[15:11];
  assign dest = (kind_q == K_LW) ? rt : rd;

  // rd is only an operand field for R-type; in LW/SW it is part of the offset.
  always_comb begin
    dec     = decode_op(instr_q[31:26], instr_q[5:0]);
    illegal = dec.illegal || !idx_ok(rs) || !idx_ok(rt) ||
              ((dec.kind == K_RTYPE) && !idx_ok(rd));
    rs_val  = (idx_ok(rs) && rs != 5'd0) ? rf[rs[IW-1:0]] : '0;
    rt_val  = (idx_ok(rt) && rt != 5'd0) ? rf[rt[IW-1:0]] : '0;
  end

  assign sext_imm = DW'($signed(instr_q[15:0]));

  // An ack arriving in the final permitted wait cycle still completes the access.
  assign tmo_hit = (state == S_MEM) && !mem_ack && (tmo_cnt == CW'(MEM_TMO - 1));

  dptr_alu #(.DW(DW)) u_alu (
    .op (alu_op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y),
    .zf (alu_zf)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (instr_valid) state_nx = S_DECODE;
      S_DECODE: state_nx = illegal ? S_WB : S_EXEC;
      S_EXEC:   state_nx = (kind_q == K_RTYPE) ? S_WB : S_MEM;
      S_MEM:    if (mem_ack || tmo_hit) state_nx = S_WB;
      S_WB:     state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == S_IDLE);
    mem_req     = (state == S_MEM);
    mem_we      = (state == S_MEM) && (kind_q == K_SW);
  end

  assign mem_addr  = AW'(alu_q);
  assign mem_wdata = rt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rt_q     <= '0;
      alu_q    <= '0;
      alu_zf_q <= 1'b0;
      ld_q     <= '0;
      kind_q   <= K_RTYPE;
      alu_op_q <= ALU_ADD;
      err_pend <= ERR_OK;
      tmo_cnt  <= '0;
      done     <= 1'b0;
      result   <= '0;
      zf       <= 1'b0;
      err      <= ERR_OK;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) instr_q <= instr;
        S_DECODE: begin
          a_q      <= rs_val;
          rt_q     <= rt_val;
          b_q      <= (dec.kind == K_RTYPE) ? rt_val : sext_imm;
          kind_q   <= dec.kind;
          alu_op_q <= dec.alu_op;
          err_pend <= illegal ? ERR_ILLEGAL : ERR_OK;
          tmo_cnt  <= '0;
        end
        S_EXEC: begin
          alu_q    <= alu_y;
          alu_zf_q <= alu_zf;
        end
        S_MEM: begin
          if (mem_ack) begin
            ld_q <= mem_rdata;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
            if (tmo_hit) err_pend <= ERR_TIMEOUT;
          end
        end
        S_WB: begin
          done <= 1'b1;
          err  <= err_pend;
          // Aborted instructions leave the previously reported result visible.
          if (err_pend == ERR_OK) begin
            result <= (kind_q == K_LW) ? ld_q : alu_q;
            zf     <= alu_zf_q;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the register bank is an array of flops that must start from zero,
  // so it takes the async reset like any other state (no RAM macro here).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (state == S_WB && err_pend == ERR_OK && kind_q != K_SW &&
                 dest != 5'd0) begin
      rf[dest[IW-1:0]] <= (kind_q == K_LW) ? ld_q : alu_q;
    end
  end

endmodule

// File: tb/tb_dptr_multiciclo.sv
// Directed, table-driven bench for dptr_multiciclo with a bench-side memory
// responder and hand-written reset-during-access sequence.
module tb_dptr_multiciclo;
  import dptr_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic          instr_ready;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          done;
  logic [DW-1:0] result;
  logic          zf;
  logic [1:0]    err;

  int n_checks = 0;
  int n_errors = 0;

  dptr_multiciclo #(.DW(DW), .AW(AW), .NREG(32), .MEM_TMO(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .done        (done),
    .result      (result),
    .zf          (zf),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    int          ack_wait;
    bit          ack_en;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] res;
    bit          zf;
    logic [1:0]  err;
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
    int          req_cycles;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [vec %0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                        input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input int aw, input bit en,
                              input logic [31:0] rdat, input int lat,
                              input logic [31:0] res, input bit z,
                              input logic [1:0] e, input bit req, input bit we,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input bit cw, input int rc);
    vec_t v;
    v.instr = ins; v.ack_wait = aw; v.ack_en = en; v.rdata = rdat; v.lat = lat;
    v.res = res; v.zf = z; v.err = e; v.req = req; v.we = we; v.addr = addr;
    v.wdata = wd; v.chk_wdata = cw; v.req_cycles = rc;
    return v;
  endfunction

  function automatic vec_t mk_r(input logic [31:0] ins, input logic [31:0] res,
                                input bit z);
    return mk(ins, 0, 0, 0, 3, res, z, ERR_OK, 0, 0, 0, 0, 0, 0);
  endfunction

  // Offers one instruction, plays the memory side, and checks the retirement.
  task automatic run(input int idx, input vec_t v);
    int          lat = 0;
    int          rc = 0;
    bit          got = 0;
    bit          saw = 0;
    logic [31:0] c_addr = '0, c_wdata = '0, r_res = '0;
    logic        c_we = 1'b0, r_zf = 1'b0;
    logic [1:0]  r_err = '0;
    check("ready_before", idx, 32'(instr_ready), 32'd1);
    instr       = v.instr;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int c = 1; c <= 64 && !got; c++) begin
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
        if (!saw) begin
          saw = 1; c_addr = mem_addr; c_wdata = mem_wdata; c_we = mem_we;
        end
        if (v.ack_en && rc == v.ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        rc++;
      end
      if (done) begin
        got = 1; lat = c; r_res = result; r_zf = zf; r_err = err;
      end
    end
    mem_ack = 1'b0;
    check("done_seen", idx, 32'(got), 32'd1);
    check("latency", idx, lat, v.lat);
    check("result", idx, r_res, v.res);
    check("zf", idx, 32'(r_zf), 32'(v.zf));
    check("err", idx, 32'(r_err), 32'(v.err));
    check("mem_req_seen", idx, 32'(saw), 32'(v.req));
    if (v.req) begin
      check("mem_we", idx, 32'(c_we), 32'(v.we));
      check("mem_addr", idx, c_addr, v.addr);
      check("req_cycles", idx, rc, v.req_cycles);
      if (v.chk_wdata) check("mem_wdata", idx, c_wdata, v.wdata);
    end
    @(posedge clk); #1;
    check("done_pulse", idx, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(itype(OP_LW, 0, 1, 16'h0100), 0, 1, 32'd5, 4, 32'd5, 0, ERR_OK,
                  1, 0, 32'h100, 0, 0, 1);
    vecs[1]  = mk(itype(OP_LW, 0, 2, 16'h0104), 1, 1, 32'd3, 5, 32'd3, 0, ERR_OK,
                  1, 0, 32'h104, 0, 0, 2);
    vecs[2]  = mk_r(rtype(1, 2, 3, FN_ADD), 32'd8, 0);
    vecs[3]  = mk_r(rtype(1, 1, 4, FN_SUB), 32'd0, 1);
    vecs[4]  = mk(itype(OP_LW, 0, 2, 16'h0108), 0, 1, 32'hFFFF_FFFF, 4,
                  32'hFFFF_FFFF, 0, ERR_OK, 1, 0, 32'h108, 0, 0, 1);
    vecs[5]  = mk_r(rtype(2, 1, 5, FN_SLT), 32'd1, 0);
    vecs[6]  = mk_r(rtype(1, 2, 8, FN_SLT), 32'd0, 1);
    vecs[7]  = mk_r(rtype(1, 2, 9, FN_AND), 32'd5, 0);
    vecs[8]  = mk_r(rtype(1, 4, 10, FN_OR), 32'd5, 0);
    vecs[9]  = mk_r(rtype(1, 4, 11, FN_NOR), 32'hFFFF_FFFA, 0);
    vecs[10] = mk_r(rtype(1, 1, 0, FN_ADD), 32'd10, 0);
    vecs[11] = mk_r(rtype(0, 0, 12, FN_OR), 32'd0, 1);
    vecs[12] = mk(itype(OP_SW, 0, 1, 16'h0010), 2, 1, 32'd0, 6, 32'h10, 0, ERR_OK,
                  1, 1, 32'h10, 32'd5, 1, 3);
    vecs[13] = mk(itype(OP_LW, 0, 6, 16'h0010), 0, 1, 32'd5, 4, 32'd5, 0, ERR_OK,
                  1, 0, 32'h10, 0, 0, 1);
    vecs[14] = mk_r(rtype(6, 5, 13, FN_ADD), 32'd6, 0);
    vecs[15] = mk(itype(OP_LW, 1, 14, 16'hFFFC), 0, 1, 32'h1234, 4, 32'h1234, 0,
                  ERR_OK, 1, 0, 32'h1, 0, 0, 1);
    vecs[16] = mk(itype(OP_LW, 0, 6, 16'h0020), 0, 0, 32'd0, 18, 32'h1234, 0,
                  ERR_TIMEOUT, 1, 0, 32'h20, 0, 0, 15);
    vecs[17] = mk_r(rtype(6, 0, 15, FN_OR), 32'd5, 0);
    vecs[18] = mk(itype(6'h3F, 1, 1, 16'h0000), 0, 0, 0, 2, 32'd5, 0, ERR_ILLEGAL,
                  0, 0, 0, 0, 0, 0);
    vecs[19] = mk(rtype(2, 2, 1, 6'h01), 0, 0, 0, 2, 32'd5, 0, ERR_ILLEGAL,
                  0, 0, 0, 0, 0, 0);
    vecs[20] = mk_r(rtype(1, 1, 16, FN_ADD), 32'd10, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", -1, 32'(instr_ready), 32'd1);
    check("rst_mem_req", -1, 32'(mem_req), 32'd0);
    check("rst_done", -1, 32'(done), 32'd0);
    check("rst_result", -1, result, 32'd0);
    check("rst_zf", -1, 32'(zf), 32'd0);
    check("rst_err", -1, 32'(err), 32'd0);
    check("rst_mem_addr", -1, mem_addr, 32'd0);

    foreach (vecs[i]) run(i, vecs[i]);

    // Reset asserted while a load waits for memory.
    begin
      bit got_req = 0;
      instr       = itype(OP_LW, 0, 1, 16'h0200);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      for (int c = 0; c < 8 && !got_req; c++) begin
        @(posedge clk); #1;
        if (mem_req) got_req = 1;
      end
      check("rstmid_req_seen", 100, 32'(got_req), 32'd1);
      check("rstmid_busy_ready", 100, 32'(instr_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rstmid_req_drop", 100, 32'(mem_req), 32'd0);
      check("rstmid_no_done", 100, 32'(done), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rstmid_ready", 100, 32'(instr_ready), 32'd1);
      check("rstmid_done", 100, 32'(done), 32'd0);
      check("rstmid_result", 100, result, 32'd0);
      check("rstmid_err", 100, 32'(err), 32'd0);
    end

    // Register bank was cleared by reset: r1 + r2 is now zero.
    run(101, mk_r(rtype(1, 2, 3, FN_ADD), 32'd0, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
